// File: rtl/load_merge_if.sv
// Request/response bundle between the memory read port, the load merge stage and writeback.
interface load_merge_if #(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [OFF_W-1:0]  in_offset;
   logic [DATA_W-1:0] in_mem_data;
   logic [DATA_W-1:0] in_reg_data;
   logic [4:0]        in_dest;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [4:0]        out_dest;
   logic              out_err;

   modport master (
      output in_valid, in_op, in_offset, in_mem_data, in_reg_data, in_dest, out_ready,
      input  in_ready, out_valid, out_data, out_dest, out_err
   );

   modport slave (
      input  in_valid, in_op, in_offset, in_mem_data, in_reg_data, in_dest, out_ready,
      output in_ready, out_valid, out_data, out_dest, out_err
   );
endinterface

// File: rtl/load_merge_unit.sv
// Registered load alignment/extension and LWL/LWR merge stage, 1-cycle latency, full throughput.
// Optional LOAD_MERGE_STATS_EN adds wrapping load/merge/error counters.
module load_merge_unit #(
   parameter int unsigned DATA_W     = 32,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   load_merge_if.slave bus
`ifdef LOAD_MERGE_STATS_EN
   ,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_merges,
   output logic [31:0] stat_errs
`endif
);
   localparam int unsigned B     = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(B);
   localparam int unsigned SH_W  = $clog2(DATA_W);

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LBU = 3'b001,
      OP_LH  = 3'b010,
      OP_LHU = 3'b011,
      OP_LW  = 3'b100,
      OP_LWL = 3'b101,
      OP_LWR = 3'b110,
      OP_RSV = 3'b111
   } op_e;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [4:0]        out_dest_q;
   logic              out_err_q;

   logic              accept;
   logic [OFF_W-1:0]  k;
   logic [SH_W-1:0]   k_sh;
   logic [SH_W-1:0]   inv_sh;
   logic [SH_W-1:0]   hw_sh;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [DATA_W-1:0] ones;
   logic [DATA_W-1:0] res_data;
   logic              res_err;
   op_e               op;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_dest  = out_dest_q;
   assign bus.out_err   = out_err_q;

   // Byte position k counts from the MSB; LE numbering mirrors the offset.
   always_comb begin
      op       = op_e'(bus.in_op);
      k        = BIG_ENDIAN ? bus.in_offset : ~bus.in_offset;
      k_sh     = {k, 3'b000};
      inv_sh   = {~k, 3'b000};
      hw_sh    = BIG_ENDIAN ? (inv_sh - SH_W'(8)) : inv_sh;
      byte_v   = 8'(bus.in_mem_data >> inv_sh);
      half_v   = 16'(bus.in_mem_data >> hw_sh);
      ones     = '1;
      res_data = '0;
      res_err  = 1'b0;
      case (op)
         OP_LB:  res_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
         OP_LBU: res_data = {{(DATA_W-8){1'b0}}, byte_v};
         OP_LH, OP_LHU: begin
            if (bus.in_offset[0]) begin
               res_err = 1'b1;
            end else begin
               res_data = {{(DATA_W-16){half_v[15] && (op == OP_LH)}}, half_v};
            end
         end
         OP_LW: begin
            if (bus.in_offset != '0) begin
               res_err = 1'b1;
            end else begin
               res_data = bus.in_mem_data;
            end
         end
         OP_LWL: res_data = (bus.in_mem_data << k_sh) | (bus.in_reg_data & ~(ones << k_sh));
         OP_LWR: res_data = (bus.in_mem_data >> inv_sh) | (bus.in_reg_data & ~(ones >> inv_sh));
         default: begin
            res_data = bus.in_mem_data;
            res_err  = 1'b1;
         end
      endcase
   end

   // Output register: load on accept, clear valid on drain, data held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dest_q  <= '0;
         out_err_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= res_data;
         out_dest_q  <= bus.in_dest;
         out_err_q   <= res_err;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef LOAD_MERGE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_merges <= '0;
         stat_errs   <= '0;
      end else if (accept) begin
         stat_loads <= stat_loads + 32'd1;
         if (op == OP_LWL || op == OP_LWR) begin
            stat_merges <= stat_merges + 32'd1;
         end
         if (res_err) begin
            stat_errs <= stat_errs + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_load_merge_unit.sv
// Directed bench for load_merge_unit: 32-bit BE and 64-bit LE instances, stall streaming,
// and counter totals when LOAD_MERGE_STATS_EN is defined.
module tb_load_merge_unit;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LBU = 3'b001;
   localparam logic [2:0] LH  = 3'b010;
   localparam logic [2:0] LHU = 3'b011;
   localparam logic [2:0] LW  = 3'b100;
   localparam logic [2:0] LWL = 3'b101;
   localparam logic [2:0] LWR = 3'b110;
   localparam logic [2:0] RSV = 3'b111;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;
   int   e_loads;
   int   e_merges;
   int   e_errs;

   load_merge_if #(.DATA_W(32)) b32 ();
   load_merge_if #(.DATA_W(64)) b64 ();

`ifdef LOAD_MERGE_STATS_EN
   logic [31:0] s32_loads, s32_merges, s32_errs;
   logic [31:0] s64_loads, s64_merges, s64_errs;
`endif

   load_merge_unit #(.DATA_W(32), .BIG_ENDIAN(1'b1)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b32)
`ifdef LOAD_MERGE_STATS_EN
      ,
      .stat_loads  (s32_loads),
      .stat_merges (s32_merges),
      .stat_errs   (s32_errs)
`endif
   );

   load_merge_unit #(.DATA_W(64), .BIG_ENDIAN(1'b0)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b64)
`ifdef LOAD_MERGE_STATS_EN
      ,
      .stat_loads  (s64_loads),
      .stat_merges (s64_merges),
      .stat_errs   (s64_errs)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One request on the 32-bit BE unit, result checked one cycle after acceptance.
   task automatic do_req(input string tag, input logic [2:0] op, input logic [1:0] off,
                         input logic [31:0] mem, input logic [31:0] rg, input logic [4:0] dest,
                         input logic [31:0] exp_d, input logic exp_e);
      @(posedge clk); #1;
      b32.in_valid    = 1'b1;
      b32.in_op       = op;
      b32.in_offset   = off;
      b32.in_mem_data = mem;
      b32.in_reg_data = rg;
      b32.in_dest     = dest;
      b32.out_ready   = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      check({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
      check({tag, "_data"},  64'(b32.out_data), 64'(exp_d));
      check({tag, "_err"},   64'(b32.out_err), 64'(exp_e));
      check({tag, "_dest"},  64'(b32.out_dest), 64'(dest));
      e_loads++;
      if (op == LWL || op == LWR) e_merges++;
      if (exp_e) e_errs++;
   endtask

   task automatic req64(input string tag, input logic [2:0] op, input logic [2:0] off,
                        input logic [63:0] mem, input logic [63:0] exp_d, input logic exp_e);
      @(posedge clk); #1;
      b64.in_valid    = 1'b1;
      b64.in_op       = op;
      b64.in_offset   = off;
      b64.in_mem_data = mem;
      b64.in_reg_data = 64'h0123_4567_89AB_CDEF;
      b64.in_dest     = 5'd7;
      b64.out_ready   = 1'b1;
      @(posedge clk); #1;
      b64.in_valid = 1'b0;
      check({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
      check({tag, "_data"},  b64.out_data, exp_d);
      check({tag, "_err"},   64'(b64.out_err), 64'(exp_e));
   endtask

   logic [2:0]  s_op   [4];
   logic [1:0]  s_off  [4];
   logic [31:0] s_mem  [4];
   logic [31:0] s_reg  [4];
   logic [31:0] s_exp  [4];
   int          tx;
   int          rx;
   int          stalls;

   initial begin
      n_chk = 0; n_bad = 0;
      e_loads = 1; e_merges = 0; e_errs = 0;
      rst_n = 1'b0;
      b32.in_valid = 1'b1; b32.in_op = LW; b32.in_offset = 2'd0;
      b32.in_mem_data = 32'hCAFE_F00D; b32.in_reg_data = '0; b32.in_dest = 5'd9;
      b32.out_ready = 1'b1;
      b64.in_valid = 1'b0; b64.in_op = LB; b64.in_offset = '0;
      b64.in_mem_data = '0; b64.in_reg_data = '0; b64.in_dest = '0; b64.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_valid", 64'(b32.out_valid), 64'd0);
      check("rst_data",  64'(b32.out_data), 64'd0);
      check("rst_err",   64'(b32.out_err), 64'd0);
      check("rst_dest",  64'(b32.out_dest), 64'd0);
      check("rst_ready", 64'(b32.in_ready), 64'd1);
      check("rst_valid64", 64'(b64.out_valid), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      check("first_valid", 64'(b32.out_valid), 64'd1);
      check("first_data",  64'(b32.out_data), 64'hCAFE_F00D);
      check("first_dest",  64'(b32.out_dest), 64'd9);

      do_req("lb_off2",   LB,  2'd2, 32'h1122_F344, 32'h0,          5'd1, 32'hFFFF_FFF3, 1'b0);
      do_req("lbu_off2",  LBU, 2'd2, 32'h1122_F344, 32'h0,          5'd2, 32'h0000_00F3, 1'b0);
      do_req("lb_off0",   LB,  2'd0, 32'h7F00_00FF, 32'h0,          5'd3, 32'h0000_007F, 1'b0);
      do_req("lwl_off1",  LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd4, 32'hBBCC_DD44, 1'b0);
      do_req("lwr_off1",  LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd5, 32'h1122_AABB, 1'b0);
      do_req("lwl_off3",  LWL, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd6, 32'hDD22_3344, 1'b0);
      do_req("lwl_off0",  LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd7, 32'hAABB_CCDD, 1'b0);
      do_req("lwr_off0",  LWR, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd8, 32'h1122_33AA, 1'b0);
      do_req("lwr_off3",  LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd9, 32'hAABB_CCDD, 1'b0);
      do_req("lh_off1",   LH,  2'd1, 32'h1234_5678, 32'h0,          5'd10, 32'h0,        1'b1);
      do_req("lh_off2",   LH,  2'd2, 32'h1234_8765, 32'h0,          5'd11, 32'hFFFF_8765, 1'b0);
      do_req("lhu_off0",  LHU, 2'd0, 32'h8765_1234, 32'h0,          5'd12, 32'h0000_8765, 1'b0);
      do_req("lw_off0",   LW,  2'd0, 32'hDEAD_BEEF, 32'h0,          5'd13, 32'hDEAD_BEEF, 1'b0);
      do_req("lw_off2",   LW,  2'd2, 32'hDEAD_BEEF, 32'h0,          5'd14, 32'h0,        1'b1);
      do_req("rsv",       RSV, 2'd1, 32'h0102_0304, 32'h0,          5'd15, 32'h0102_0304, 1'b1);

      // Stream of 4 with writeback stalled during the 2nd and 3rd cycles.
      s_op[0] = LW;  s_off[0] = 2'd0; s_mem[0] = 32'h1111_1111; s_reg[0] = '0;           s_exp[0] = 32'h1111_1111;
      s_op[1] = LBU; s_off[1] = 2'd3; s_mem[1] = 32'h0000_00AB; s_reg[1] = '0;           s_exp[1] = 32'h0000_00AB;
      s_op[2] = LWL; s_off[2] = 2'd2; s_mem[2] = 32'hA1B2_C3D4; s_reg[2] = 32'h5566_7788; s_exp[2] = 32'hC3D4_7788;
      s_op[3] = LH;  s_off[3] = 2'd1; s_mem[3] = 32'hFFFF_FFFF; s_reg[3] = '0;           s_exp[3] = 32'h0;
      tx = 0; rx = 0; stalls = 0;
      for (int c = 0; c < 20 && rx < 4; c++) begin
         @(posedge clk); #1;
         b32.out_ready = !(c == 1 || c == 2);
         if (tx < 4) begin
            b32.in_valid    = 1'b1;
            b32.in_op       = s_op[tx];
            b32.in_offset   = s_off[tx];
            b32.in_mem_data = s_mem[tx];
            b32.in_reg_data = s_reg[tx];
            b32.in_dest     = 5'(20 + tx);
         end else begin
            b32.in_valid = 1'b0;
         end
         @(negedge clk);
         if (b32.out_valid) begin
            check("strm_data", 64'(b32.out_data), 64'(s_exp[rx]));
            check("strm_dest", 64'(b32.out_dest), 64'(20 + rx));
            if (!b32.out_ready) begin
               stalls++;
               check("strm_stall_ready", 64'(b32.in_ready), 64'd0);
            end
         end
         if (b32.out_valid && b32.out_ready) rx++;
         if (b32.in_valid && b32.in_ready) tx++;
      end
      b32.in_valid = 1'b0;
      b32.out_ready = 1'b1;
      check("strm_delivered", 64'(rx), 64'd4);
      check("strm_accepted",  64'(tx), 64'd4);
      check("strm_stalls",    64'(stalls), 64'd2);
      e_loads += 4; e_merges += 1; e_errs += 1;
      @(posedge clk); #1;
      check("drain_valid", 64'(b32.out_valid), 64'd0);
      check("drain_hold",  64'(b32.out_data), 64'd0);

      req64("lhu64_off6", LHU, 3'd6, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 1'b0);
      req64("lb64_off0",  LB,  3'd0, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      req64("lw64_off4",  LW,  3'd4, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1);
      req64("lw64_off0",  LW,  3'd0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);

`ifdef LOAD_MERGE_STATS_EN
      @(negedge clk);
      check("stat32_loads",  64'(s32_loads),  64'(e_loads));
      check("stat32_merges", 64'(s32_merges), 64'(e_merges));
      check("stat32_errs",   64'(s32_errs),   64'(e_errs));
      check("stat64_loads",  64'(s64_loads),  64'd4);
      check("stat64_merges", 64'(s64_merges), 64'd0);
      check("stat64_errs",   64'(s64_errs),   64'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
